dma_uart_read: RTL
==================

# dma_uart_read

Read-direction companion of the UART DMA engine. It fetches one fp16 value from the host at a 7-bit host address: it sends a read command byte, collects the two reply bytes, and widens the value to an 18-bit cherry float for the core. It sits between the DMA controller and a shared `uart_tx` / `uart_rx` pair that the parent instantiates. A timeout guards against a silent host.

## Interface
- `TIMEOUT_CYCLES`, default 200000: clock cycles allowed for each awaited reply byte before the transaction aborts. Must be ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `re`  in  1  read request; sampled only in IDLE.
- `dma_dat_addr`  in  7  host address; latched when `re` is accepted.
- `busy`  out  1  high from the cycle after `re` is accepted until the result cycle.
- `dma_dat_r`  out  18  result cherry float; holds its value between transactions.
- `dma_dat_r_valid`  out  1  one-cycle pulse when `dma_dat_r` is updated.
- `dma_err`  out  1  high if the last transaction aborted; cleared when the next `re` is accepted.
- `uart_tx_data`  out  8  command byte to `uart_tx`.
- `uart_tx_en`  out  1  one-cycle send strobe.
- `uart_tx_busy`  in  1  transmitter busy.
- `uart_rx_valid`  in  1  one-cycle received-byte strobe.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_break`  in  1  line break detected.

## Operation
- Wire protocol:
  - Read command byte = {1'b0, addr}. The write engine uses bit 7 = 1 for writes.
  - Host replies with the fp16 MSB byte, then the LSB byte.
- Conversion: `dma_dat_r` = {msb, lsb, 2'b00}. The mantissa is zero-extended, which is the exact inverse of the write path's truncation.
- All outputs are registered.
- States and transitions:
  - IDLE: on `re`, latch the address, set `busy`=1, clear `dma_err`, go to SEND_CMD.
  - SEND_CMD: set `uart_tx_en`=1 and `uart_tx_data`={0,addr}; go to GUARD.
  - GUARD: set `uart_tx_en`=0; go to WAIT_TX. This gives `uart_tx_busy` one cycle to assert.
  - WAIT_TX: when `uart_tx_busy`=0, go to RECV_MSB. A `uart_rx_valid` in this state is accepted as the MSB and the state goes directly to RECV_LSB.
  - RECV_MSB: on `uart_rx_valid`, capture the MSB and go to RECV_LSB.
  - RECV_LSB: on `uart_rx_valid`, update `dma_dat_r`, pulse `dma_dat_r_valid`, set `busy`=0, go to IDLE.
- Timeout counter:
  - Cleared on entering RECV_MSB and when the MSB is accepted.
  - Increments every cycle in RECV_MSB and RECV_LSB.
  - Abort when it reaches TIMEOUT_CYCLES−1 with no `uart_rx_valid` that cycle.
- Abort, caused by timeout or by `uart_rx_break` in WAIT_TX / RECV_*:
  - `dma_dat_r` ← 0, `dma_dat_r_valid` pulse, `dma_err` ← 1, `busy` ← 0, go to IDLE.
- Boundary rules:
  - `re` while `busy` is ignored and not queued.
  - `uart_rx_valid` in IDLE, SEND_CMD or GUARD: byte discarded, no output change.
  - `uart_rx_valid` in the same cycle as a timeout: the byte wins and there is no abort.
  - `uart_rx_break` together with `uart_rx_valid`: the break wins.
  - `re` in the same cycle as a `dma_dat_r_valid` pulse: accepted, because the state is already IDLE.
- Reset, including mid-transaction:
  - State → IDLE.
  - `busy`, `uart_tx_en`, `dma_dat_r_valid` and `dma_err` → 0.
  - `uart_tx_data`, `dma_dat_r` and the counter → 0.
  - Partial bytes are dropped.

## Timing
- Edge E0 samples `re`=1:
  - `busy` is high from E0+1.
  - `uart_tx_en` is high for exactly the cycle after E0+1 and low after E0+2.
- Minimum latency from `re` to `dma_dat_r_valid`: tx completion + 2 rx bytes + 1 cycle.
  - Result registers on the edge that sees the LSB `uart_rx_valid`.
  - `dma_dat_r_valid` and `busy`=0 appear in the same cycle.
- `dma_dat_r_valid` is never high for 2 consecutive cycles.
- Abort timing: after MSB arrival, the abort occurs exactly TIMEOUT_CYCLES cycles after entering RECV_LSB.

## Test plan
- Basic read:
  - Stimulus: `re` with addr 0x15; after tx completes, bytes 0x3C then 0x00.
  - Required: `uart_tx_data`=0x15 with one `uart_tx_en` pulse; `dma_dat_r`=0x0F000; one valid pulse; `dma_err`=0.
- Sign and mantissa:
  - Stimulus: addr 0x7F, reply 0xC1, 0x23.
  - Required: cmd 0x7F; `dma_dat_r`=0x3048C.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, reply only 0x12.
  - Required: abort 16 cycles after the MSB; `dma_dat_r`=0, `dma_err`=1, `busy`=0.
  - Then a new `re`: `dma_err` clears next cycle.
- Ignored inputs:
  - Stimulus: stray 0xAA in IDLE, then `re` pulses while busy.
  - Required: no output change, and exactly one command byte is sent.
- Mid-transaction reset and break:
  - Stimulus: reset asserted after the MSB; separately, `uart_rx_break` during RECV_LSB.
  - Required: after reset, all outputs are 0 immediately (async). After the break, the abort response matches the timeout case.

Source files
------------

// File: rtl/dma_uart_read_if.sv
// Handshake bundle between the DMA controller, the read engine and the shared UART pair.
interface dma_uart_read_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DAT_W  = 18;

    logic              re;
    logic [ADDR_W-1:0] dma_dat_addr;
    logic              busy;
    logic [DAT_W-1:0]  dma_dat_r;
    logic              dma_dat_r_valid;
    logic              dma_err;
    logic [BYTE_W-1:0] uart_tx_data;
    logic              uart_tx_en;
    logic              uart_tx_busy;
    logic              uart_rx_valid;
    logic [BYTE_W-1:0] uart_rx_data;
    logic              uart_rx_break;

    // Controller / UART side: issues requests and reply bytes.
    modport master (
        output re, dma_dat_addr, uart_tx_busy, uart_rx_valid, uart_rx_data, uart_rx_break,
        input  busy, dma_dat_r, dma_dat_r_valid, dma_err, uart_tx_data, uart_tx_en
    );

    // Read engine side.
    modport slave (
        input  re, dma_dat_addr, uart_tx_busy, uart_rx_valid, uart_rx_data, uart_rx_break,
        output busy, dma_dat_r, dma_dat_r_valid, dma_err, uart_tx_data, uart_tx_en
    );
endinterface

// File: rtl/dma_uart_read.sv
// UART DMA read engine: sends a read command byte, collects the fp16 reply
// and widens it to an 18-bit cherry float, with a per-byte reply timeout.
module dma_uart_read #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input logic            clk,
    input logic            reset,
    dma_uart_read_if.slave bus
);
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DAT_W  = 18;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_CMD = 3'd1;
    localparam logic [2:0] S_GUARD    = 3'd2;
    localparam logic [2:0] S_WAIT_TX  = 3'd3;
    localparam logic [2:0] S_RECV_MSB = 3'd4;
    localparam logic [2:0] S_RECV_LSB = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [BYTE_W-1:0] msb_q,     msb_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic [DAT_W-1:0]  dat_q,     dat_d;
    logic              valid_q,   valid_d;
    logic              err_q,     err_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_en_q,   tx_en_d;
    logic              abort_c;
    logic              timeout_c;

    assign timeout_c = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; abort overrides whatever the state chose.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        msb_d     = msb_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        dat_d     = dat_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        abort_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.re) begin
                    addr_d  = bus.dma_dat_addr;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_SEND_CMD;
                end
            end
            S_SEND_CMD: begin
                tx_en_d   = 1'b1;
                tx_data_d = {1'b0, addr_q};
                state_d   = S_GUARD;
            end
            S_GUARD: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // A fast host may reply before the transmitter reports idle.
                if (bus.uart_rx_break) begin
                    abort_c = 1'b1;
                end else if (bus.uart_rx_valid) begin
                    msb_d   = bus.uart_rx_data;
                    cnt_d   = '0;
                    state_d = S_RECV_LSB;
                end else if (!bus.uart_tx_busy) begin
                    cnt_d   = '0;
                    state_d = S_RECV_MSB;
                end
            end
            S_RECV_MSB: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.uart_rx_break) begin
                    abort_c = 1'b1;
                end else if (bus.uart_rx_valid) begin
                    msb_d   = bus.uart_rx_data;
                    cnt_d   = '0;
                    state_d = S_RECV_LSB;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                end
            end
            S_RECV_LSB: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.uart_rx_break) begin
                    abort_c = 1'b1;
                end else if (bus.uart_rx_valid) begin
                    dat_d   = {msb_q, bus.uart_rx_data, 2'b00};
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_c) begin
            dat_d   = '0;
            valid_d = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            msb_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            dat_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            msb_q     <= msb_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            dat_q     <= dat_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.dma_dat_r       = dat_q;
    assign bus.dma_dat_r_valid = valid_q;
    assign bus.dma_err         = err_q;
    assign bus.uart_tx_data    = tx_data_q;
    assign bus.uart_tx_en      = tx_en_q;
endmodule
